// File: rtl/jk_up_counter_sync_if.sv
// Counter control/status bundle for jk_up_counter_sync.
// The master side drives enable and load and observes the count, tc and wrap.
// The slave side is the counter itself.
interface jk_up_counter_sync_if #(
    parameter int WIDTH = 5
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;

    modport master (
        output en,
        output load,
        output load_val,
        input  count,
        input  tc,
        input  wrap
    );

    modport slave (
        input  en,
        input  load,
        input  load_val,
        output count,
        output tc,
        output wrap
    );
endinterface

// File: rtl/jk_up_counter_sync.sv
// jk_up_counter_sync: synchronous modulo-MODULUS up counter.
// The counter is built from per-bit JK cells with J=K=t[i].
// t[0] is en, and each t[i] is t[i-1] AND count[i-1].
// Every bit is clocked directly by clk.
// The wrap from MODULUS-1 to 0 is a synchronous clear.
// A load overrides the toggle inputs.
// tc is en AND (count == MODULUS-1), so the next stage can use it as its enable.
// The next stage then advances on the same edge where this stage wraps.
// wrap is a registered one-cycle pulse that follows the terminal edge.
// Optional build macro: JK_UP_COUNTER_SATURATE_EN.
// When it is defined, the count holds at MODULUS-1 and wrap stays 0.
module jk_up_counter_sync #(
    parameter int WIDTH   = 5,
    parameter int MODULUS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    jk_up_counter_sync_if.slave   bus
);

    localparam logic [WIDTH-1:0] TERM    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] jk_next;
    logic             wrap_q;
    logic             wrap_d;
    logic             at_term;

    // Classic JK characteristic: set, reset, toggle or hold.
    function automatic logic jk_cell(input logic q, input logic j, input logic k);
        return (j & ~q) | (~k & q);
    endfunction

    // Out-of-range load values collapse to 0, so no state >= MODULUS is reachable.
    function automatic logic [WIDTH-1:0] load_clip(input logic [WIDTH-1:0] v);
        return ({1'b0, v} >= MOD_EXT) ? '0 : v;
    endfunction

    assign at_term = (count_q == TERM);

    // Toggle-enable chain and the JK next state of each bit.
    always_comb begin
        logic run;
        run = bus.en;
        for (int i = 0; i < WIDTH; i++) begin
            t[i]       = run;
            run        = run & count_q[i];
            jk_next[i] = jk_cell(count_q[i], t[i], t[i]);
        end
    end

    // Next-state selection: load, then the terminal clear/hold, then toggle, then hold.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (bus.load) begin
            count_d = load_clip(bus.load_val);
        end else if (bus.en && at_term) begin
`ifdef JK_UP_COUNTER_SATURATE_EN
            count_d = count_q;
            wrap_d  = 1'b0;
`else
            count_d = '0;
            wrap_d  = 1'b1;
`endif
        end else if (bus.en) begin
            count_d = jk_next;
        end
    end

    // State registers; an asynchronous reset clears the count and any pending wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.count = count_q;
    assign bus.wrap  = wrap_q;
    assign bus.tc    = bus.en & at_term;

endmodule

// File: tb/tb_jk_up_counter_sync.sv
// Directed bench for jk_up_counter_sync.
// u_a uses the default parameters (WIDTH=5, MODULUS=32).
// u_b uses WIDTH=4, MODULUS=10.
module tb_jk_up_counter_sync;

`ifdef JK_UP_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    jk_up_counter_sync_if #(.WIDTH(5)) a_if ();
    jk_up_counter_sync_if #(.WIDTH(4)) b_if ();

    jk_up_counter_sync #(.WIDTH(5), .MODULUS(32)) u_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if.slave)
    );

    jk_up_counter_sync #(.WIDTH(4), .MODULUS(10)) u_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp;

        reset       = 1'b1;
        a_if.en     = 1'b0;
        a_if.load   = 1'b0;
        a_if.load_val = '0;
        b_if.en     = 1'b0;
        b_if.load   = 1'b0;
        b_if.load_val = '0;
        #2;
        chk("rst_a_count", 32'(a_if.count), 0);
        chk("rst_a_wrap",  32'(a_if.wrap),  0);
        chk("rst_a_tc",    32'(a_if.tc),    0);
        chk("rst_b_count", 32'(b_if.count), 0);
        tick();
        tick();
        reset = 1'b0;

        // T1: an asynchronous reset in mid-count takes effect without a clock edge.
        a_if.en = 1'b1;
        repeat (13) tick();
        chk("t1_pre13", 32'(a_if.count), 13);
        reset = 1'b1;
        #1;
        chk("t1_async_count", 32'(a_if.count), 0);
        chk("t1_async_wrap",  32'(a_if.wrap),  0);
        chk("t1_async_tc",    32'(a_if.tc),    0);
        reset = 1'b0;
        repeat (3) tick();
        chk("t1_after3", 32'(a_if.count), 3);

        // T2: full cycle with the default modulus.
        a_if.en       = 1'b0;
        a_if.load     = 1'b1;
        a_if.load_val = 5'd0;
        tick();
        a_if.load = 1'b0;
        a_if.en   = 1'b1;
        #1;
        for (int k = 0; k < 32; k++) begin
            chk("t2_count", 32'(a_if.count), 32'(k));
            chk("t2_tc",    32'(a_if.tc),    32'(k == 31));
            chk("t2_wrap",  32'(a_if.wrap),  0);
            tick();
        end
        chk("t2_term_count", 32'(a_if.count), SAT ? 31 : 0);
        chk("t2_wrap_pulse", 32'(a_if.wrap),  SAT ? 0 : 1);
        tick();
        chk("t2_wrap_end",   32'(a_if.wrap),  0);
        chk("t2_next_count", 32'(a_if.count), SAT ? 31 : 1);
        a_if.en = 1'b0;

        // T3: modulus 10 sequence.
        b_if.en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            exp = SAT ? ((k + 1 > 9) ? 32'd9 : 32'(k + 1)) : 32'((k + 1) % 10);
            chk("t3_count", 32'(b_if.count), exp);
            chk("t3_range", 32'(b_if.count < 4'd10), 1);
            chk("t3_wrap",  32'(b_if.wrap), 32'(!SAT && k == 9));
        end
        b_if.en = 1'b0;

        // T4: parallel loads, including out-of-range values and a load at the terminal count.
        a_if.load     = 1'b1;
        a_if.load_val = 5'd7;
        a_if.en       = 1'b1;
        tick();
        chk("t4_a_load7", 32'(a_if.count), 7);
        a_if.load = 1'b0;
        a_if.en   = 1'b0;

        b_if.load     = 1'b1;
        b_if.load_val = 4'd7;
        b_if.en       = 1'b1;
        tick();
        chk("t4_b_load7", 32'(b_if.count), 7);
        chk("t4_b_wrap7", 32'(b_if.wrap),  0);
        b_if.load_val = 4'd12;
        tick();
        chk("t4_load12", 32'(b_if.count), 0);
        b_if.load_val = 4'd10;
        tick();
        chk("t4_load10", 32'(b_if.count), 0);
        b_if.load_val = 4'd9;
        tick();
        chk("t4_load9", 32'(b_if.count), 9);
        b_if.load_val = 4'd3;
        #1;
        chk("t4_tc_at9", 32'(b_if.tc), 1);
        tick();
        chk("t4_load_wins",  32'(b_if.count), 3);
        chk("t4_load_nowrap", 32'(b_if.wrap), 0);
        b_if.load = 1'b0;
        b_if.en   = 1'b0;

        // T5: the enable pattern 1,0,0,1 starting from 4.
        b_if.load     = 1'b1;
        b_if.load_val = 4'd4;
        tick();
        b_if.load = 1'b0;
        b_if.en   = 1'b1;
        tick();
        chk("t5_e1", 32'(b_if.count), 5);
        b_if.en = 1'b0;
        tick();
        chk("t5_e0a", 32'(b_if.count), 5);
        tick();
        chk("t5_e0b", 32'(b_if.count), 5);
        b_if.en = 1'b1;
        tick();
        chk("t5_e1b", 32'(b_if.count), 6);
        b_if.en = 1'b0;

        b_if.load     = 1'b1;
        b_if.load_val = 4'd9;
        tick();
        b_if.load = 1'b0;
        #1;
        chk("t5_tc_en0", 32'(b_if.tc), 0);
        b_if.en = 1'b1;
        #1;
        chk("t5_tc_en1", 32'(b_if.tc), 1);
        b_if.en = 1'b0;
        #1;
        chk("t5_tc_fall", 32'(b_if.tc), 0);
        tick();
        chk("t5_hold9",   32'(b_if.count), 9);
        chk("t5_no_wrap", 32'(b_if.wrap),  0);

`ifdef JK_UP_COUNTER_SATURATE_EN
        // T6: saturating build.
        reset = 1'b1;
        #1;
        reset   = 1'b0;
        a_if.en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            chk("t6_wrap", 32'(a_if.wrap), 0);
        end
        chk("t6_sat31", 32'(a_if.count), 31);
        chk("t6_tc",    32'(a_if.tc),    1);
        reset = 1'b1;
        #1;
        chk("t6_reset", 32'(a_if.count), 0);
        reset   = 1'b0;
        a_if.en = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
